// File: rtl/connect4_drop_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : connect4_drop_ctrl_if
// Description : Button, column-counter and board-write signals of the
//               Connect-4 move controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface connect4_drop_ctrl_if;
    logic [3:0]  column;
    logic        drop;
    logic [11:0] count;
    logic        add;
    logic        wr_en;
    logic [1:0]  wr_col;
    logic [2:0]  wr_row;
    logic        wr_player;
    logic        player;
    logic        busy;
    logic        reject;
    logic        board_full;

    modport master (
        output column, drop, count,
        input  add, wr_en, wr_col, wr_row, wr_player, player, busy, reject, board_full
    );

    modport slave (
        input  column, drop, count,
        output add, wr_en, wr_col, wr_row, wr_player, player, busy, reject, board_full
    );
endinterface
`default_nettype wire

// File: rtl/connect4_drop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : connect4_drop_ctrl
// Description : Validates a drop request against the column heights, issues
//               the board write and the counter increment, tracks the turn.
// Revision    : 1.0 - initial release
// ============================================================================
module connect4_drop_ctrl #(
    parameter int ROWS = 6,
    parameter int COLS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    connect4_drop_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_WRITE    = 3'd2,
        S_ADD      = 3'd3,
        S_REJ      = 3'd4,
        S_WAIT_REL = 3'd5
    } state_t;

    localparam logic [2:0] c_ROWS = 3'(ROWS);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_drop_q;
    logic [3:0]  r_col_q;
    logic [11:0] r_cnt_q;
    logic        r_add;
    logic        r_wr_en;
    logic        r_reject;
    logic        r_busy;
    logic        r_board_full;
    logic [1:0]  r_wr_col;
    logic [2:0]  r_wr_row;
    logic        r_wr_player;
    logic        r_player;

    logic        w_req;
    logic        w_col_valid;
    logic [1:0]  w_col_idx;
    logic [2:0]  w_height;
    logic        w_all_full;

    assign w_req = bus.drop & ~r_drop_q;

    // Codes with zero or several low bits match no column and stay invalid.
    always_comb begin
        w_col_valid = 1'b0;
        w_col_idx   = '0;
        w_height    = '0;
        for (int i = 0; i < COLS; i++) begin
            if (r_col_q == ~(4'b0001 << i)) begin
                w_col_valid = 1'b1;
                w_col_idx   = 2'(i);
                w_height    = r_cnt_q[3*i +: 3];
            end
        end
    end

    always_comb begin
        w_all_full = 1'b1;
        for (int i = 0; i < COLS; i++) begin
            if (bus.count[3*i +: 3] != c_ROWS) begin
                w_all_full = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_req) w_state_nxt = S_CHECK;
            S_CHECK:    w_state_nxt = (!w_col_valid || (w_height >= c_ROWS)) ? S_REJ : S_WRITE;
            S_WRITE:    w_state_nxt = S_ADD;
            S_ADD:      w_state_nxt = S_WAIT_REL;
            S_REJ:      w_state_nxt = S_WAIT_REL;
            S_WAIT_REL: if (!bus.drop) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave straight from flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_drop_q     <= 1'b0;
            r_col_q      <= '0;
            r_cnt_q      <= '0;
            r_add        <= 1'b0;
            r_wr_en      <= 1'b0;
            r_reject     <= 1'b0;
            r_busy       <= 1'b0;
            r_board_full <= 1'b0;
            r_wr_col     <= '0;
            r_wr_row     <= '0;
            r_wr_player  <= 1'b0;
            r_player     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_drop_q     <= bus.drop;
            r_board_full <= w_all_full;
            r_add        <= (w_state_nxt == S_ADD);
            r_wr_en      <= (w_state_nxt == S_WRITE);
            r_reject     <= (w_state_nxt == S_REJ);
            r_busy       <= (w_state_nxt != S_IDLE);
            if (r_state == S_IDLE && w_req) begin
                r_col_q <= bus.column;
                r_cnt_q <= bus.count;
            end
            if (r_state == S_CHECK && w_state_nxt == S_WRITE) begin
                r_wr_col    <= w_col_idx;
                r_wr_row    <= w_height;
                r_wr_player <= r_player;
            end
            if (r_state == S_ADD) begin
                r_player <= ~r_player;
            end
        end
    end

    assign bus.add        = r_add;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_col     = r_wr_col;
    assign bus.wr_row     = r_wr_row;
    assign bus.wr_player  = r_wr_player;
    assign bus.player     = r_player;
    assign bus.busy       = r_busy;
    assign bus.reject     = r_reject;
    assign bus.board_full = r_board_full;

endmodule
`default_nettype wire

// File: tb/tb_connect4_drop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_connect4_drop_ctrl
// Description : Directed self-checking bench for connect4_drop_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_connect4_drop_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    connect4_drop_ctrl_if bus_if ();

    connect4_drop_ctrl #(
        .ROWS (6),
        .COLS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold drop for 'hold' cycles, release, and tally every strobe seen.
    task automatic run_move(input logic [3:0] col, input logic [11:0] cnt, input int hold,
                            output int n_add, output int n_wr, output int n_rej,
                            output int w_col, output int w_row, output int w_pl);
        n_add = 0; n_wr = 0; n_rej = 0;
        w_col = -1; w_row = -1; w_pl = -1;
        bus_if.column = col;
        bus_if.count  = cnt;
        bus_if.drop   = 1'b1;
        for (int i = 0; i < hold + 4; i++) begin
            if (i == hold) bus_if.drop = 1'b0;
            step();
            if (bus_if.add)    n_add++;
            if (bus_if.reject) n_rej++;
            if (bus_if.wr_en) begin
                n_wr++;
                w_col = int'(bus_if.wr_col);
                w_row = int'(bus_if.wr_row);
                w_pl  = int'(bus_if.wr_player);
            end
        end
    endtask

    int na, nw, nr, wc, wrw, wp;

    initial begin
        reset         = 1'b0;
        bus_if.drop   = 1'b0;
        bus_if.column = 4'b1111;
        bus_if.count  = 12'h000;
        repeat (3) step();
        check_eq("rst_player", int'(bus_if.player), 0);
        check_eq("rst_busy",   int'(bus_if.busy),   0);
        check_eq("rst_add",    int'(bus_if.add),    0);
        check_eq("rst_wr_en",  int'(bus_if.wr_en),  0);
        check_eq("rst_reject", int'(bus_if.reject), 0);
        check_eq("rst_full",   int'(bus_if.board_full), 0);
        reset = 1'b1;
        step();

        // Legal drop in column 1, cycle by cycle
        bus_if.column = 4'b1101;
        bus_if.count  = 12'h000;
        bus_if.drop   = 1'b1;
        step();
        check_eq("c1_busy",  int'(bus_if.busy),  1);
        check_eq("c1_wr_en", int'(bus_if.wr_en), 0);
        step();
        check_eq("c2_wr_en",   int'(bus_if.wr_en),     1);
        check_eq("c2_wr_col",  int'(bus_if.wr_col),    1);
        check_eq("c2_wr_row",  int'(bus_if.wr_row),    0);
        check_eq("c2_wr_pl",   int'(bus_if.wr_player), 0);
        check_eq("c2_add",     int'(bus_if.add),       0);
        step();
        check_eq("c3_add",   int'(bus_if.add),   1);
        check_eq("c3_wr_en", int'(bus_if.wr_en), 0);
        step();
        check_eq("c4_add",    int'(bus_if.add),    0);
        check_eq("c4_player", int'(bus_if.player), 1);
        check_eq("c4_busy",   int'(bus_if.busy),   1);
        bus_if.drop = 1'b0;
        step();
        check_eq("rel_busy", int'(bus_if.busy), 0);
        step();

        // Full column 2
        run_move(4'b1011, {3'd0, 3'd6, 3'd0, 3'd0}, 6, na, nw, nr, wc, wrw, wp);
        check_eq("full_rej",    nr, 1);
        check_eq("full_add",    na, 0);
        check_eq("full_wr",     nw, 0);
        check_eq("full_player", int'(bus_if.player), 1);
        check_eq("full_busy",   int'(bus_if.busy),   0);

        // Invalid column codes
        run_move(4'b1100, 12'h000, 6, na, nw, nr, wc, wrw, wp);
        check_eq("inv1100_rej", nr, 1);
        check_eq("inv1100_add", na, 0);
        run_move(4'b1111, 12'h000, 6, na, nw, nr, wc, wrw, wp);
        check_eq("inv1111_rej", nr, 1);
        check_eq("inv1111_wr",  nw, 0);
        check_eq("inv_player",  int'(bus_if.player), 1);

        // Legal drop in column 3 by player 2
        run_move(4'b0111, 12'h000, 6, na, nw, nr, wc, wrw, wp);
        check_eq("c3_mv_add", na, 1);
        check_eq("c3_mv_col", wc, 3);
        check_eq("c3_mv_pl",  wp, 1);
        check_eq("c3_mv_player", int'(bus_if.player), 0);

        // Held button: one move only
        run_move(4'b1110, 12'h002, 20, na, nw, nr, wc, wrw, wp);
        check_eq("held_add", na, 1);
        check_eq("held_wr",  nw, 1);
        check_eq("held_row", wrw, 2);
        check_eq("held_player", int'(bus_if.player), 1);
        run_move(4'b1110, 12'h003, 6, na, nw, nr, wc, wrw, wp);
        check_eq("again_row", wrw, 3);
        check_eq("again_pl",  wp, 1);
        check_eq("again_add", na, 1);
        check_eq("again_player", int'(bus_if.player), 0);

        run_move(4'b1011, 12'h000, 6, na, nw, nr, wc, wrw, wp);
        check_eq("pre_rst_player", int'(bus_if.player), 1);

        // Reset during WRITE aborts the move
        bus_if.column = 4'b1101;
        bus_if.count  = 12'h000;
        bus_if.drop   = 1'b1;
        step();
        step();
        check_eq("mid_wr_en", int'(bus_if.wr_en), 1);
        reset       = 1'b0;
        bus_if.drop = 1'b0;
        step();
        check_eq("mid_add",    int'(bus_if.add),    0);
        check_eq("mid_player", int'(bus_if.player), 0);
        check_eq("mid_busy",   int'(bus_if.busy),   0);
        check_eq("mid_wr_row", int'(bus_if.wr_row), 0);
        reset = 1'b1;
        na = 0; nw = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus_if.add)   na++;
            if (bus_if.wr_en) nw++;
        end
        check_eq("post_rst_add", na, 0);
        check_eq("post_rst_wr",  nw, 0);

        // Board full
        bus_if.count  = {4{3'd6}};
        bus_if.column = 4'b1111;
        check_eq("bf_before", int'(bus_if.board_full), 0);
        step();
        check_eq("bf_after", int'(bus_if.board_full), 1);
        run_move(4'b1110, {4{3'd6}}, 6, na, nw, nr, wc, wrw, wp);
        check_eq("bf_rej", nr, 1);
        check_eq("bf_add", na, 0);

        // Height 7 counts as full; board_full needs every height equal to ROWS
        run_move(4'b0111, {3'd7, 9'd0}, 6, na, nw, nr, wc, wrw, wp);
        check_eq("h7_rej", nr, 1);
        check_eq("h7_add", na, 0);
        check_eq("h7_bf",  int'(bus_if.board_full), 0);

        // Top legal row
        run_move(4'b1011, {3'd0, 3'd5, 6'd0}, 6, na, nw, nr, wc, wrw, wp);
        check_eq("h5_add", na, 1);
        check_eq("h5_row", wrw, 5);
        check_eq("h5_col", wc, 2);
        check_eq("h5_pl",  wp, 0);
        check_eq("h5_player", int'(bus_if.player), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/connect4_drop_ctrl.md
# connect4_drop_ctrl

Move controller that consumes the packed per-column piece heights produced by the column counter and turns a player's drop request into a board write plus a single increment pulse back to that counter. It sits between the debounced column/drop buttons and the board store, validates each move, and tracks whose turn it is. It is the reader/driver side of the counter interface: it reads `count[11:0]` and drives `add`.

## Interface
Parameters:
- `ROWS`, 6: playable rows per column; legal heights are 0..ROWS-1, and ROWS must be ≤ 7.
- `COLS`, 4: number of columns; fixed to match the 4-bit column code and the 12-bit count.

Ports:
- `clk` input 1: single system clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-low.
- `column` input 4: active-low one-hot column select (1110=col0, 1101=col1, 1011=col2, 0111=col3).
- `drop` input 1: debounced drop request (level), synchronous to `clk`.
- `count` input 12: column heights {h3,h2,h1,h0}, 3 bits each, from the column counter.
- `add` output 1: one-cycle increment pulse to the column counter; `column` is held unchanged during it.
- `wr_en` output 1: one-cycle board write strobe.
- `wr_col` output 2: column index of the write.
- `wr_row` output 3: row index of the write; row 0 is the bottom.
- `wr_player` output 1: owner of the written piece.
- `player` output 1: current turn (0 = player 1).
- `busy` output 1: high in every state except IDLE.
- `reject` output 1: one-cycle pulse for an illegal move.
- `board_full` output 1: registered; high when every height equals ROWS.

## Operation
- Edge detection: `drop_q` is a registered copy of `drop`. A request is `drop & ~drop_q`, and it is honoured only in IDLE.
- FSM states: IDLE, CHECK, WRITE, ADD, REJ, WAIT_REL.
- IDLE: on a request, latch `column` into `col_q` and `count` into `cnt_q`, then go to CHECK.
- CHECK: decode `col_q` to an index.
  - Invalid when `col_q` is not exactly one low bit (e.g. 1111, 1100).
  - Full when the selected 3-bit height is ≥ ROWS.
  - Invalid or full goes to REJ. Otherwise capture `wr_col`, `wr_row` = height, and `wr_player` = `player`, then go to WRITE.
- WRITE: `wr_en`=1 for one cycle, then ADD.
- ADD: `add`=1 for one cycle, `player` toggles at the end of the cycle, then WAIT_REL.
- REJ: `reject`=1 for one cycle. `player` is unchanged and there is no `add` and no `wr_en`. Then WAIT_REL.
- WAIT_REL: stay until `drop`=0, then return to IDLE. A held button therefore never produces a second move.
- `board_full` is recomputed every cycle from `count`. It does not block the FSM, because full columns already reject.
- Height arithmetic is 3-bit unsigned with no wrap. Any height ≥ ROWS, including 7, counts as full.
- Requests arriving in any state other than IDLE are ignored.

## Timing
- Cycle 0 is the first cycle IDLE samples `drop`=1 with `drop_q`=0; `col_q`/`cnt_q` latch at the end of it.
- Legal move:
  - cycle 1: CHECK, `busy`=1.
  - cycle 2: `wr_en`=1.
  - cycle 3: `add`=1.
  - cycle 4: `player` shows the new value, state is WAIT_REL.
- Illegal move: cycle 1 CHECK, cycle 2 `reject`=1, cycle 3 WAIT_REL.
- `wr_col`, `wr_row`, and `wr_player` are stable from cycle 2 until the next accepted move.
- `add` and `wr_en` come straight from registers (glitch-free), because the counter is edge-sensitive on `add`.
- The counter's `count` must reflect the increment before the next IDLE request. WAIT_REL plus the release/re-press gap guarantees this.
- Reset (`reset`=0 at a clock edge) has priority in every state:
  - state goes to IDLE.
  - `player`, `add`, `wr_en`, `reject`, `busy`, `board_full`, `wr_col`, `wr_row`, `wr_player`, and `drop_q` all go to 0.
- Reset during WRITE or ADD aborts the move: no further `add` or `wr_en` is issued.
- A request is recognised only from the first cycle after `reset` returns high. A level already high when reset releases counts as an edge, because `drop_q` is 0.

## Test plan
- **Legal drop.** `count`=12'h000, `column`=1101, `drop` rises → `wr_en`=1 at cycle 2 with `wr_col`=1, `wr_row`=0, `wr_player`=0; `add`=1 at cycle 3; `player`=1 at cycle 4.
- **Full column.** `count`={3'd0,3'd6,3'd0,3'd0} (col2=6), `column`=1011, drop → `reject`=1 at cycle 2; no `add` or `wr_en`; `player` unchanged.
- **Invalid code.** `column`=1100 and then 1111, drop each time → `reject` pulse each time; `player` unchanged.
- **Held button.** `drop` held high for 20 cycles after a legal move → exactly one `add` pulse. Release, press again with `count` h0=3, `column`=1110 → `wr_row`=3 and `wr_player`=1.
- **Mid-move reset.** `reset`=0 in the WRITE cycle → no `add`, `player`=0, `busy`=0 the next cycle.
- **Board full.** `count`={4{3'd6}} → `board_full`=1 one cycle later, and any drop is rejected.
